multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multicycle RV32I datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, and generates the 3-bit `alu_control` code consumed by the ALU. It also keeps a retired-instruction counter and halts on any opcode or funct3 the datapath cannot execute.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `instr[6:0]` from the instruction register.
- `funct3`  in  3  `instr[14:12]`.
- `funct7b5`  in  1  `instr[30]`.
- `zero`  in  1  ALU zero flag.
- `pc_write`  out  1  PC load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = Result.
- `mem_write`  out  1  data memory write strobe.
- `ir_write`  out  1  instruction register and OldPC load.
- `reg_write`  out  1  register file write strobe.
- `result_src`  out  2  Result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `alu_src_b`  out  2  ALU B mux: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J; decoded combinationally from `opcode`.
- `alu_control`  out  3  ALU operation: 000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT.
- `halted`  out  1  high in the ERROR state.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ERROR.

Transitions:
- FETCH always goes to DECODE.
- DECODE branches on `opcode`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Any other opcode → ERROR.
- DECODE also checks `funct3`:
  - For R-type and I-type, `funct3` must be one of {000, 010, 110, 111}; anything else → ERROR.
  - For branches, `funct3` must be 000 or 001; anything else → ERROR.
- MEMADR → MEMREAD for a load (`opcode[5]` = 0) or MEMWRITE for a store (`opcode[5]` = 1).
- MEMREAD → MEMWB.
- EXECR, EXECI and JAL → ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH → FETCH.
- ERROR is absorbing until reset.

Outputs per state. Any strobe not listed is 0; any select not listed is 00.
- FETCH: `adr_src`=0, `ir_write`=1, `alu_src_a`=00, `alu_src_b`=10, ALU ADD, `result_src`=10, `pc_write`=1.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, ALU ADD. This computes the branch/jump target into ALUOut.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, ALU ADD.
- MEMREAD: `result_src`=00, `adr_src`=1.
- MEMWRITE: `result_src`=00, `adr_src`=1, `mem_write`=1.
- MEMWB: `result_src`=01, `reg_write`=1.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, ALU per funct decode.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, ALU per funct decode.
- ALUWB: `result_src`=00, `reg_write`=1.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, ALU SUB, `result_src`=00.
  - `pc_write` = `zero` when `funct3`=000 (beq).
  - `pc_write` = `~zero` when `funct3`=001 (bne).
- JAL: `alu_src_a`=01, `alu_src_b`=10, ALU ADD, `result_src`=00, `pc_write`=1.
- ERROR: all strobes 0, `halted`=1.

Funct decode, used only in EXECR and EXECI:
- `funct3` 000 → ADD, or SUB when in EXECR and `funct7b5`=1. In EXECI, 000 is always ADD.
- `funct3` 010 → SLT.
- `funct3` 110 → OR.
- `funct3` 111 → AND.

Retired-instruction counter:
- `instret` increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BRANCH.
- It wraps modulo 2^`INSTRET_W`.
- ERROR never increments it.

## Timing
- Reset: while `resetn`=0, state = FETCH, `instret` = 0, and `pc_write`, `mem_write`, `ir_write`, `reg_write` and `halted` are forced to 0.
- Asserting reset mid-instruction aborts the instruction with no increment.
- On the first rising edge after `resetn` rises, the FETCH strobes take effect.
- All outputs are combinational from the state register and the IR fields; there are no output registers.
- The BRANCH-state `pc_write` additionally depends on `zero` within the same cycle.
- Cycles per instruction:
  - lw: 5.
  - sw, R-type, I-type and jal: 4.
  - beq and bne: 3.
- The IR is loaded at the end of FETCH. `opcode` and `funct` fields are therefore valid from DECODE onward, and `imm_src` is only meaningful from DECODE on.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles mid-EXECR → state FETCH, `instret`=0, all strobes 0. After release, the first cycle shows `ir_write`=1 and `pc_write`=1.
- R-type sequence with `opcode`=0110011:
  - `funct3`=000, `funct7b5`=1 → in EXECR `alu_control`=110; ALUWB has `reg_write`=1; 4 cycles total; `instret` +1.
  - `funct3`=111 → `alu_control`=000.
- addi with `funct7b5`=1 (`opcode`=0010011, `funct3`=000) → EXECI `alu_control`=010, not SUB.
- lw then sw:
  - lw visits FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `result_src`=01 in MEMWB.
  - sw reaches MEMWRITE with `mem_write`=1 and `adr_src`=1.
  - `instret` is 2 after both.
- Branches:
  - beq with `zero`=1 in BRANCH → `pc_write`=1.
  - beq with `zero`=0 → `pc_write`=0.
  - bne with `zero`=0 → `pc_write`=1.
  - Each takes 3 cycles.
- Illegal instructions:
  - `opcode`=1110011 → ERROR after DECODE; `halted`=1, strobes stay 0 for 10 cycles, `instret` frozen.
  - Same for R-type with `funct3`=001.
  - Only `resetn`=0 clears the ERROR state.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control unit for the multicycle RV32I datapath: Moore FSM driving
// datapath strobes and mux selects, ALU operation decode and retired-instruction counter.
module multicycle_control #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [2:0]           alu_control,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    state_t               state_q, state_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire_s;
    logic                 pc_write_s, mem_write_s, ir_write_s, reg_write_s, halted_s;

    function automatic logic alu_f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Next-state logic and retire detection
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:    state_d = alu_f3_legal(funct3) ? S_EXECR : S_ERROR;
                    OP_I:    state_d = alu_f3_legal(funct3) ? S_EXECI : S_ERROR;
                    OP_BR:   state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ERROR;
                    OP_JAL:  state_d = S_JAL;
                    default: state_d = S_ERROR;
                endcase
            end
            S_MEMADR:  state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
        if (retire_s) begin
            instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // State and retired-instruction counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_FETCH;
            instret_q <= {INSTRET_W{1'b0}};
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Moore output decode per state
    always_comb begin
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        halted_s    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_AND;
        case (state_q)
            S_FETCH: begin
                ir_write_s  = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                result_src  = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7b5);
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, 1'b0);
            end
            S_ALUWB:  reg_write_s = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write_s  = funct3[0] ? ~zero : zero;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                pc_write_s  = 1'b1;
            end
            S_ERROR:  halted_s = 1'b1;
            default:  halted_s = 1'b1;
        endcase
    end

    // Immediate format from the opcode alone
    always_comb begin
        case (opcode)
            OP_STORE: imm_src = 2'b01;
            OP_BR:    imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    // Reset overrides the FETCH strobes so nothing fires while held in reset
    assign pc_write  = resetn & pc_write_s;
    assign mem_write = resetn & mem_write_s;
    assign ir_write  = resetn & ir_write_s;
    assign reg_write = resetn & reg_write_s;
    assign halted    = resetn & halted_s;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, random instruction stream against
// a phase-sequence reference model, and hand-written reset/illegal sequences.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        resetn;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, halted;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_control #(.INSTRET_W(32)) dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .halted(halted), .instret(instret)
    );

    logic [14:0] dut_vec;
    assign dut_vec = {pc_write, adr_src, mem_write, ir_write, reg_write, halted,
                      result_src, alu_src_a, alu_src_b, alu_control};

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_instret;

    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BR, P_J} phase_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic [3:0] cycles;
        logic [2:0] alu2;
        logic       pcw2;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        if (f3 == 3'b000) return (is_r && f7) ? 3'b110 : 3'b010;
        if (f3 == 3'b010) return 3'b111;
        if (f3 == 3'b110) return 3'b001;
        return 3'b000;
    endfunction

    // Expected outputs of one phase, packed like dut_vec; mask drops alu_control where unspecified
    function automatic void exp_out(input phase_t p, input logic [2:0] f3, input logic f7,
                                    input logic z, output logic [14:0] e, output logic [14:0] m);
        logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0;
        logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00;
        logic [2:0] alu = 3'b000;
        logic chk_alu = 1'b0;
        case (p)
            P_F:   begin irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10; alu = 3'b010; chk_alu = 1'b1; end
            P_D:   begin sa = 2'b01; sb = 2'b01; alu = 3'b010; chk_alu = 1'b1; end
            P_MA:  begin sa = 2'b10; sb = 2'b01; alu = 3'b010; chk_alu = 1'b1; end
            P_MR:  adr = 1'b1;
            P_MW:  begin adr = 1'b1; mw = 1'b1; end
            P_MWB: begin rs = 2'b01; rw = 1'b1; end
            P_ER:  begin sa = 2'b10; alu = ref_alu(f3, f7, 1'b1); chk_alu = 1'b1; end
            P_EI:  begin sa = 2'b10; sb = 2'b01; alu = ref_alu(f3, f7, 1'b0); chk_alu = 1'b1; end
            P_AWB: rw = 1'b1;
            P_BR:  begin sa = 2'b10; alu = 3'b110; chk_alu = 1'b1; pcw = (f3 == 3'b000) ? z : !z; end
            P_J:   begin sa = 2'b01; sb = 2'b10; alu = 3'b010; chk_alu = 1'b1; pcw = 1'b1; end
            default: ;
        endcase
        e = {pcw, adr, mw, irw, rw, 1'b0, rs, sa, sb, alu};
        m = chk_alu ? 15'h7fff : 15'h7ff8;
    endfunction

    // Table row: count cycles until the next FETCH, sample ALU op and pc_write on cycle 2
    task automatic run_vec(input vec_t v);
        int n = 0;
        logic [2:0] a = 3'b000;
        logic p = 1'b0;
        opcode = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
        do begin
            tick(); #1;
            n++;
            if (n == 2) begin a = alu_control; p = pc_write; end
        end while (ir_write !== 1'b1 && n < 12);
        chk("vec_cycles", n, {28'd0, v.cycles});
        chk("vec_alu", {29'd0, a}, {29'd0, v.alu2});
        chk("vec_pcw", {31'd0, p}, {31'd0, v.pcw2});
        exp_instret++;
    endtask

    // Random instruction of class cls, checked phase by phase against the model
    task automatic run_model(input int cls);
        phase_t ph[$];
        logic [6:0] op;
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        logic [1:0] iexp = 2'b00;
        logic ichk = 1'b1;
        logic [14:0] e, m;
        logic [2:0] alu_set[4];
        alu_set[0] = 3'b000; alu_set[1] = 3'b010; alu_set[2] = 3'b110; alu_set[3] = 3'b111;
        case (cls)
            0: begin op = 7'b0000011; ph = '{P_F, P_D, P_MA, P_MR, P_MWB}; end
            1: begin op = 7'b0100011; iexp = 2'b01; ph = '{P_F, P_D, P_MA, P_MW}; end
            2: begin op = 7'b0110011; ichk = 1'b0; f3 = alu_set[$urandom_range(0, 3)]; ph = '{P_F, P_D, P_ER, P_AWB}; end
            3: begin op = 7'b0010011; f3 = alu_set[$urandom_range(0, 3)]; ph = '{P_F, P_D, P_EI, P_AWB}; end
            4: begin op = 7'b1100011; iexp = 2'b10; f3 = 3'($urandom_range(0, 1)); ph = '{P_F, P_D, P_BR}; end
            default: begin op = 7'b1101111; iexp = 2'b11; ph = '{P_F, P_D, P_J, P_AWB}; end
        endcase
        opcode = op; funct3 = f3; funct7b5 = 1'($urandom_range(0, 1));
        for (int i = 0; i < ph.size(); i++) begin
            if (i > 0) tick();
            zero = 1'($urandom_range(0, 1));
            #1;
            exp_out(ph[i], f3, funct7b5, zero, e, m);
            chk("phase_out", {17'd0, dut_vec & m}, {17'd0, e & m});
            if (i > 0 && ichk) chk("imm_src", {30'd0, imm_src}, {30'd0, iexp});
        end
        tick(); #1;
        exp_instret++;
        chk("instret", instret, exp_instret);
    endtask

    task automatic do_reset_release();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        exp_instret = 32'd0;
    endtask

    // Illegal instruction: ERROR after DECODE, stays halted with strobes low until reset
    task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] frozen;
        opcode = op; funct3 = f3; funct7b5 = 1'b0; zero = 1'b1;
        tick(); #1;
        chk("decode_not_halted", {31'd0, halted}, 32'd0);
        frozen = instret;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk("err_halted", {31'd0, halted}, 32'd1);
            chk("err_strobes", {28'd0, pc_write, mem_write, ir_write, reg_write}, 32'd0);
            chk("err_instret", instret, frozen);
        end
        do_reset_release();
        chk("err_cleared", {30'd0, halted, ir_write}, 32'd1);
        chk("err_instret_rst", instret, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 4'd5, 3'b010, 1'b0};
        vecs[1]  = '{7'b0100011, 3'b010, 1'b1, 1'b0, 4'd4, 3'b010, 1'b0};
        vecs[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4'd4, 3'b110, 1'b0};
        vecs[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b1, 4'd4, 3'b010, 1'b0};
        vecs[4]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4'd4, 3'b000, 1'b0};
        vecs[5]  = '{7'b0110011, 3'b010, 1'b1, 1'b0, 4'd4, 3'b111, 1'b0};
        vecs[6]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4'd4, 3'b010, 1'b0};
        vecs[7]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 4'd4, 3'b001, 1'b0};
        vecs[8]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 4'd3, 3'b110, 1'b1};
        vecs[9]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 4'd3, 3'b110, 1'b0};
        vecs[10] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 4'd3, 3'b110, 1'b1};
        vecs[11] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4'd4, 3'b010, 1'b1};
        vecs[12] = '{7'b1100011, 3'b001, 1'b1, 1'b1, 4'd3, 3'b110, 1'b0};
        vecs[13] = '{7'b0110011, 3'b110, 1'b1, 1'b1, 4'd4, 3'b001, 1'b0};
        vecs[14] = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4'd4, 3'b111, 1'b0};
        vecs[15] = '{7'b0010011, 3'b111, 1'b1, 1'b0, 4'd4, 3'b000, 1'b0};

        resetn = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        exp_instret = 32'd0;
        tick(); tick(); #1;
        chk("rst_strobes", {27'd0, pc_write, mem_write, ir_write, reg_write, halted}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        resetn = 1'b1; #1;
        chk("rel_fetch", {30'd0, ir_write, pc_write}, 32'd3);

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("table_instret", instret, exp_instret);

        for (int k = 0; k < 150; k++) run_model($urandom_range(0, 5));

        // Reset held for 3 cycles in the middle of an R-type
        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;
        tick(); tick(); #1;
        chk("execr_sub", {29'd0, alu_control}, 32'd6);
        resetn = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_strobes", {27'd0, pc_write, mem_write, ir_write, reg_write, halted}, 32'd0);
            chk("midrst_instret", instret, 32'd0);
            tick(); #1;
        end
        resetn = 1'b1; #1;
        exp_instret = 32'd0;
        chk("midrst_fetch", {30'd0, ir_write, pc_write}, 32'd3);

        run_model(0);
        run_model(1);
        chk("lw_sw_instret", instret, 32'd2);

        run_illegal(7'b1110011, 3'b000);
        run_illegal(7'b0110011, 3'b001);
        run_illegal(7'b0010011, 3'b100);
        run_illegal(7'b1100011, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
